// File: rtl/current_adc_reader.sv
// Serial 12-bit ADC reader: paces conversions and clocks in 16-bit frames.
// Averages 2^AVG_LOG2 codes, scales them to mA and clamps to 0..999 for the display bus.
module current_adc_reader #(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 10000,
    parameter int AVG_LOG2      = 4,
    parameter int SCALE_NUM     = 1000,
    parameter int SCALE_SHIFT   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adc_sdata,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [11:0] raw_sample,
    output logic [11:0] current_num,
    output logic        sample_valid
);

    localparam int TW    = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = 12 + AVG_LOG2;
    localparam int CW    = AVG_LOG2 + 1;
    localparam int NSAMP = 1 << AVG_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [DW-1:0]   div_reg, div_next;
    logic [3:0]      bit_reg, bit_next;
    logic [11:0]     shift_reg, shift_next;
    logic            cs_reg, cs_next;
    logic            sclk_reg, sclk_next;
    logic [11:0]     raw_reg, raw_next;
    logic [AW-1:0]   acc_reg, acc_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [11:0]     num_reg, num_next;
    logic            valid_reg, valid_next;

    logic            tick;
    logic            div_last;
    logic [11:0]     avg;
    logic [27:0]     prod;
    logic [27:0]     ma;

    assign tick     = (timer_reg == '0);
    assign div_last = (div_reg == DW'(CLK_DIV - 1));
    assign avg      = acc_reg[AW-1:AVG_LOG2];
    assign prod     = {16'd0, avg} * 28'(SCALE_NUM);
    assign ma       = prod >> SCALE_SHIFT;

    assign timer_next = (timer_reg == TW'(SAMPLE_PERIOD - 1)) ? '0 : timer_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        cs_next    = cs_reg;
        sclk_next  = sclk_reg;
        raw_next   = raw_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        num_next   = num_reg;
        valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                cs_next   = 1'b1;
                sclk_next = 1'b1;
                bit_next  = '0;
                if (tick) begin
                    state_next = SETUP;
                    cs_next    = 1'b0;
                    div_next   = '0;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_next = SHIFT;
                    sclk_next  = 1'b0;
                    div_next   = '0;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_next  = '0;
                    sclk_next = ~sclk_reg;
                    // Sample on the edge that raises SCLK; the ADC changes data on the fall.
                    // Only 12 bits are kept, so the four leading zeros fall off the top.
                    if (!sclk_reg) begin
                        shift_next = {shift_reg[10:0], adc_sdata};
                        bit_next   = bit_reg + 1'b1;
                        if (bit_reg == 4'd15) begin
                            state_next = DONE;
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            DONE: begin
                cs_next    = 1'b1;
                sclk_next  = 1'b1;
                raw_next   = shift_reg;
                acc_next   = acc_reg + AW'(shift_reg);
                cnt_next   = cnt_reg + 1'b1;
                bit_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cs_next    = 1'b1;
                sclk_next  = 1'b1;
            end
        endcase

        // The counter only reaches a full block in the cycle right after DONE.
        if (cnt_reg == CW'(NSAMP)) begin
            valid_next = 1'b1;
            num_next   = (ma > 28'd999) ? 12'd999 : ma[11:0];
            acc_next   = '0;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            cs_reg    <= 1'b1;
            sclk_reg  <= 1'b1;
            raw_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            num_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            cs_reg    <= cs_next;
            sclk_reg  <= sclk_next;
            raw_reg   <= raw_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            num_reg   <= num_next;
            valid_reg <= valid_next;
        end
    end

    assign adc_cs_n     = cs_reg;
    assign adc_sclk     = sclk_reg;
    assign raw_sample   = raw_reg;
    assign current_num  = num_reg;
    assign sample_valid = valid_reg;

endmodule
